// File: rtl/watchdog_pkg.sv
// Shared constants, types and next-action decode for the watchdog timer.
// The action decode captures the input priority: enable, force_reset, triggered, heartbeat.
package watchdog_pkg;

    localparam int unsigned COUNTER_WIDTH          = 32;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;
    localparam int unsigned DEFAULT_WARNING_CYCLES = 12;

    typedef logic [COUNTER_WIDTH-1:0] count_t;

    typedef enum logic [2:0] {
        ACT_CLEAR,
        ACT_FORCE,
        ACT_HOLD,
        ACT_KICK,
        ACT_COUNT
    } wd_action_e;

    function automatic wd_action_e decode_action(
        input logic enable,
        input logic triggered,
        input logic force_reset,
        input logic heartbeat
    );
        wd_action_e act;
        if (!enable) begin
            act = ACT_CLEAR;
        end else if (force_reset) begin
            act = ACT_FORCE;
        end else if (triggered) begin
            act = ACT_HOLD;
        end else if (heartbeat) begin
            act = ACT_KICK;
        end else begin
            act = ACT_COUNT;
        end
        return act;
    endfunction

endpackage

// File: rtl/watchdog_timer.sv
// Watchdog timer with pre-timeout warning, sticky trigger and software-forced trip.
// Define WATCHDOG_FORMAL_EN to compile the embedded formal properties.
module watchdog_timer
    import watchdog_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned WARNING_CYCLES = DEFAULT_WARNING_CYCLES
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     enable,
    input  logic                     heartbeat,
    input  logic                     force_reset,
    output logic                     triggered,
    output logic                     warning,
    output logic [COUNTER_WIDTH-1:0] counter
);

    // One extra bit so counter+1 can never wrap in the comparisons.
    localparam logic [COUNTER_WIDTH:0] TIMEOUT_EXT = (COUNTER_WIDTH+1)'(TIMEOUT_CYCLES);
    localparam logic [COUNTER_WIDTH:0] WARNING_EXT = (COUNTER_WIDTH+1)'(WARNING_CYCLES);

    if (TIMEOUT_CYCLES < 2 || WARNING_CYCLES < 1 || WARNING_CYCLES >= TIMEOUT_CYCLES) begin : g_bad_params
        $error("watchdog_timer: illegal TIMEOUT_CYCLES/WARNING_CYCLES combination");
    end

    count_t               counter_reg, counter_next;
    logic                 warning_reg, warning_next;
    logic                 triggered_reg, triggered_next;
    logic [COUNTER_WIDTH:0] count_inc;
    wd_action_e           action;

    always_comb begin
        action         = decode_action(enable, triggered_reg, force_reset, heartbeat);
        count_inc      = {1'b0, counter_reg} + {{COUNTER_WIDTH{1'b0}}, 1'b1};
        counter_next   = counter_reg;
        warning_next   = warning_reg;
        triggered_next = triggered_reg;
        case (action)
            ACT_CLEAR: begin
                counter_next   = '0;
                warning_next   = 1'b0;
                triggered_next = 1'b0;
            end
            ACT_FORCE: begin
                triggered_next = 1'b1;
                warning_next   = 1'b0;
            end
            ACT_KICK: begin
                counter_next = '0;
                warning_next = 1'b0;
            end
            ACT_COUNT: begin
                counter_next = count_inc[COUNTER_WIDTH-1:0];
                if (count_inc == TIMEOUT_EXT) begin
                    triggered_next = 1'b1;
                    warning_next   = 1'b0;
                end else begin
                    warning_next = (count_inc >= WARNING_EXT);
                end
            end
            default: begin
                // ACT_HOLD: a tripped watchdog freezes until disabled or reset
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            counter_reg   <= '0;
            warning_reg   <= 1'b0;
            triggered_reg <= 1'b0;
        end else begin
            counter_reg   <= counter_next;
            warning_reg   <= warning_next;
            triggered_reg <= triggered_next;
        end
    end

    assign counter   = counter_reg;
    assign warning   = warning_reg;
    assign triggered = triggered_reg;

`ifdef WATCHDOG_FORMAL_EN
    logic f_past_valid_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            f_past_valid_reg <= 1'b0;
        end else begin
            f_past_valid_reg <= 1'b1;
        end
    end

    a_exclusive_flags: assert property (@(posedge clk) !(triggered_reg && warning_reg));
    a_counter_bound:   assert property (@(posedge clk) counter_reg <= TIMEOUT_EXT[COUNTER_WIDTH-1:0]);
    a_reset_clears:    assert property (@(posedge clk) !rstn |-> (counter_reg == '0 && !warning_reg && !triggered_reg));
    a_force_trips:     assert property (@(posedge clk) disable iff (!rstn)
                           (f_past_valid_reg && $past(rstn && enable && force_reset))
                           |-> (triggered_reg && !warning_reg && counter_reg == $past(counter_reg)));
    c_timeout_rise:    cover property (@(posedge clk) disable iff (!rstn)
                           f_past_valid_reg && $rose(triggered_reg) && $past(action) == ACT_COUNT);
    c_trigger_clear:   cover property (@(posedge clk) f_past_valid_reg && $fell(triggered_reg));
`else
    // Functional build: no formal logic.
`endif

endmodule

// File: tb/tb_watchdog_timer.sv
// Self-checking bench for watchdog_timer: expected outputs are queued as stimulus is applied.
module tb_watchdog_timer;
    import watchdog_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        heartbeat = 1'b0;
    logic        force_reset = 1'b0;
    logic        triggered;
    logic        warning;
    logic [31:0] counter;

    typedef struct packed {
        logic [31:0] cnt;
        logic        warn;
        logic        trig;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    watchdog_timer dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .heartbeat  (heartbeat),
        .force_reset(force_reset),
        .triggered  (triggered),
        .warning    (warning),
        .counter    (counter)
    );

    always #5 clk = ~clk;

    // Apply inputs, take one rising edge, sample 1 time unit later.
    task automatic drive(input logic en, input logic hb, input logic fr);
        enable      = en;
        heartbeat   = hb;
        force_reset = fr;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int c, input logic w, input logic t);
        exp_t e;
        e.cnt  = 32'(c);
        e.warn = w;
        e.trig = t;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        #1;
        push_exp(0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if ({counter, warning, triggered} !== {e.cnt, e.warn, e.trig})
            begin errors++; $display("FAIL reset_state: got cnt=%0d warn=%b trig=%b, expected cnt=%0d warn=%b trig=%b", counter, warning, triggered, e.cnt, e.warn, e.trig); end
        else $display("reset_state: cnt=%0d warn=%b trig=%b ok", counter, warning, triggered);
        for (int i = 0; i < 2; i++) begin
            push_exp(0, 1'b0, 1'b0);
            drive(1'b1, 1'b0, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({counter, warning, triggered} !== {e.cnt, e.warn, e.trig})
                begin errors++; $display("FAIL reset_held[%0d]: got cnt=%0d warn=%b trig=%b, expected cnt=%0d warn=%b trig=%b", i, counter, warning, triggered, e.cnt, e.warn, e.trig); end
            else $display("reset_held[%0d]: cnt=%0d ok", i, counter);
        end
        #3 rstn = 1'b1;
    endtask

    // Uninterrupted counting: warning from edge 12, trigger at 16, then saturate.
    task automatic test_count_up();
        exp_t e;
        int   c;
        for (int i = 1; i <= 19; i++) begin
            c = (i > 16) ? 16 : i;
            push_exp(c, (c >= 12 && c < 16), (c == 16));
            drive(1'b1, 1'b0, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({counter, warning, triggered} !== {e.cnt, e.warn, e.trig})
                begin errors++; $display("FAIL count_up[%0d]: got cnt=%0d warn=%b trig=%b, expected cnt=%0d warn=%b trig=%b", i, counter, warning, triggered, e.cnt, e.warn, e.trig); end
            else $display("count_up[%0d]: cnt=%0d warn=%b trig=%b ok", i, counter, warning, triggered);
        end
    endtask

    // Sticky trigger ignores heartbeat; enable=0 clears; counting restarts from 0.
    task automatic test_sticky();
        exp_t e;
        logic en_t [0:5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic hb_t [0:5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int   c_t  [0:5] = '{16, 16, 0, 1, 2, 3};
        logic t_t  [0:5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            push_exp(c_t[i], 1'b0, t_t[i]);
            drive(en_t[i], hb_t[i], 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({counter, warning, triggered} !== {e.cnt, e.warn, e.trig})
                begin errors++; $display("FAIL sticky[%0d]: got cnt=%0d warn=%b trig=%b, expected cnt=%0d warn=%b trig=%b", i, counter, warning, triggered, e.cnt, e.warn, e.trig); end
            else $display("sticky[%0d]: cnt=%0d trig=%b ok", i, counter, triggered);
        end
    endtask

    // Disabled watchdog ignores heartbeat and force_reset.
    task automatic test_idle();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            push_exp(0, 1'b0, 1'b0);
            drive(1'b0, i[0], 1'b1);
            e = exp_q.pop_front();
            checks++;
            if ({counter, warning, triggered} !== {e.cnt, e.warn, e.trig})
                begin errors++; $display("FAIL idle[%0d]: got cnt=%0d warn=%b trig=%b, expected cnt=%0d warn=%b trig=%b", i, counter, warning, triggered, e.cnt, e.warn, e.trig); end
            else $display("idle[%0d]: cnt=%0d ok", i, counter);
        end
    endtask

    // Kick at counter=10, then the full timeout is needed again.
    task automatic test_kick();
        exp_t e;
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i <= 16; i++) begin
            push_exp(i, (i >= 12 && i < 16), (i == 16));
            drive(1'b1, (i == 0), 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({counter, warning, triggered} !== {e.cnt, e.warn, e.trig})
                begin errors++; $display("FAIL kick[%0d]: got cnt=%0d warn=%b trig=%b, expected cnt=%0d warn=%b trig=%b", i, counter, warning, triggered, e.cnt, e.warn, e.trig); end
            else $display("kick[%0d]: cnt=%0d warn=%b trig=%b ok", i, counter, warning, triggered);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    // force_reset beats heartbeat at counter=5, and clears warning at counter=13.
    task automatic test_force();
        exp_t e;
        int   pre_t [0:1] = '{5, 13};
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < pre_t[k]; i++) drive(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 2; i++) begin
                push_exp(pre_t[k], 1'b0, 1'b1);
                drive(1'b1, (k == 0), (i == 0));
                e = exp_q.pop_front();
                checks++;
                if ({counter, warning, triggered} !== {e.cnt, e.warn, e.trig})
                    begin errors++; $display("FAIL force[%0d.%0d]: got cnt=%0d warn=%b trig=%b, expected cnt=%0d warn=%b trig=%b", k, i, counter, warning, triggered, e.cnt, e.warn, e.trig); end
                else $display("force[%0d.%0d]: cnt=%0d trig=%b ok", k, i, counter, triggered);
            end
            drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    // Heartbeat on the edge that would reach the timeout wins.
    task automatic test_boundary();
        exp_t e;
        for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 1'b0);
        push_exp(15, 1'b1, 1'b0);
        push_exp(0, 1'b0, 1'b0);
        push_exp(1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            if (i > 0) drive(1'b1, (i == 1), 1'b0);
            checks++;
            if ({counter, warning, triggered} !== {e.cnt, e.warn, e.trig})
                begin errors++; $display("FAIL boundary[%0d]: got cnt=%0d warn=%b trig=%b, expected cnt=%0d warn=%b trig=%b", i, counter, warning, triggered, e.cnt, e.warn, e.trig); end
            else $display("boundary[%0d]: cnt=%0d warn=%b trig=%b ok", i, counter, warning, triggered);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset between edges, mid-count and while triggered.
    task automatic test_async_reset();
        exp_t e;
        int   pre_t [0:1] = '{14, 16};
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < pre_t[k]; i++) drive(1'b1, 1'b0, 1'b0);
            #2 rstn = 1'b0;
            #1;
            push_exp(0, 1'b0, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({counter, warning, triggered} !== {e.cnt, e.warn, e.trig})
                begin errors++; $display("FAIL async_rst[%0d]: got cnt=%0d warn=%b trig=%b, expected cnt=%0d warn=%b trig=%b", k, counter, warning, triggered, e.cnt, e.warn, e.trig); end
            else $display("async_rst[%0d]: cleared between edges ok", k);
            #1 rstn = 1'b1;
            for (int i = 1; i <= 2; i++) begin
                push_exp(i, 1'b0, 1'b0);
                drive(1'b1, 1'b0, 1'b0);
                e = exp_q.pop_front();
                checks++;
                if ({counter, warning, triggered} !== {e.cnt, e.warn, e.trig})
                    begin errors++; $display("FAIL async_resume[%0d.%0d]: got cnt=%0d warn=%b trig=%b, expected cnt=%0d warn=%b trig=%b", k, i, counter, warning, triggered, e.cnt, e.warn, e.trig); end
                else $display("async_resume[%0d.%0d]: cnt=%0d ok", k, i, counter);
            end
            drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_sticky();
        drive(1'b0, 1'b0, 1'b0);
        test_idle();
        test_kick();
        test_force();
        test_boundary();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
